a_buffer_tile_sequencer: RTL and testbench

Sequences the activation buffer across a full A operand of cfg_rows rows, each row holding cfg_depth words. It splits the operand into tiles of at most ARRAY_N rows. For each tile it issues one `on` pulse with the matching base_addr and num_rows, then waits for the array to report completion. It sits between the top-level layer controller (start/done) and the activation buffer's address-generation inputs (on, base_addr, num_rows).

---
 rtl/a_buffer_tile_sequencer.sv | 115 +++++++++++
 tb/tb_a_buffer_tile_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_buffer_tile_sequencer.sv
// Activation-buffer tile sequencer: walks an A operand in ARRAY_N-row
// tiles, launching one buffer pass per tile and waiting for completion.
module a_buffer_tile_sequencer #(
  parameter int RAM_SIZE   = 1024,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int ARRAY_N    = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CNT_WIDTH-1:0]      cfg_rows,
  input  logic [ADDR_WIDTH-1:0]     cfg_depth,
  input  logic [ADDR_WIDTH-1:0]     cfg_base,
  input  logic                      array_ready,
  input  logic                      tile_done,
  output logic                      on,
  output logic [ADDR_WIDTH-1:0]     base_addr,
  output logic [$clog2(ARRAY_N):0]  num_rows,
  output logic [CNT_WIDTH-1:0]      tile_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int NW = $clog2(ARRAY_N) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [NW-1:0]        TILE_MAX = NW'(ARRAY_N);
  localparam logic [CNT_WIDTH-1:0] TILE_CNT = CNT_WIDTH'(ARRAY_N);
  localparam logic [ADDR_WIDTH:0]  RAM_LIM  = (ADDR_WIDTH+1)'(RAM_SIZE);

  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  rows_left;
  logic [CNT_WIDTH-1:0]  rows_next;
  logic [ADDR_WIDTH-1:0] depth;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  ovf;

  function automatic logic [NW-1:0] tile_rows(
    input logic [CNT_WIDTH-1:0] r
  );
    return (r >= TILE_CNT) ? TILE_MAX : r[NW-1:0];
  endfunction

  // One extra bit so a tile ending past the RAM is seen, not wrapped
  assign end_addr  = {1'b0, base_addr} + {1'b0, depth};
  assign ovf       = end_addr > RAM_LIM;
  assign rows_next = rows_left - CNT_WIDTH'(num_rows);

  assign on   = (state == ISSUE) && !abort && !ovf && array_ready;
  assign done = (state == FIN) && !abort;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rows_left <= '0;
      depth     <= '0;
      base_addr <= '0;
      num_rows  <= '0;
      tile_idx  <= '0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rows_left <= cfg_rows;
            depth     <= cfg_depth;
            base_addr <= cfg_base;
            tile_idx  <= '0;
            num_rows  <= tile_rows(cfg_rows);
            if (cfg_rows == '0 || cfg_depth == '0) begin
              err   <= 1'b1;
              state <= FIN;
            end else begin
              err   <= 1'b0;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (abort) begin
            state <= IDLE;
          end else if (ovf) begin
            err   <= 1'b1;
            state <= FIN;
          end else if (array_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            state <= IDLE;
          end else if (tile_done) begin
            rows_left <= rows_next;
            base_addr <= base_addr + depth;
            tile_idx  <= tile_idx + CNT_WIDTH'(1);
            num_rows  <= tile_rows(rows_next);
            state     <= (rows_next == '0) ? FIN : ISSUE;
          end
        end
        FIN: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a_buffer_tile_sequencer.sv
// Bench for a_buffer_tile_sequencer: tile-list model plus a per-cycle
// compare process and directed timing expectations.
module tb_a_buffer_tile_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] cfg_rows;
  logic [9:0]  cfg_depth;
  logic [9:0]  cfg_base;
  logic        array_ready;
  logic        tile_done;
  logic        on;
  logic [9:0]  base_addr;
  logic [3:0]  num_rows;
  logic [15:0] tile_idx;
  logic        busy;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int c0 = 0;
  int done_cyc = -1;
  int done_pend = 0;
  bit exp_err = 1'b0;
  int exp_base[$];
  int exp_rows[$];
  int exp_idx[$];
  int on_cyc[$];
  int td_delay = 16;
  bit td_echo = 1'b0;

  a_buffer_tile_sequencer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .cfg_rows(cfg_rows),
    .cfg_depth(cfg_depth),
    .cfg_base(cfg_base),
    .array_ready(array_ready),
    .tile_done(tile_done),
    .on(on),
    .base_addr(base_addr),
    .num_rows(num_rows),
    .tile_idx(tile_idx),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Expected tile list from the operand shape alone
  task automatic plan_run(input int rows, input int depth, input int base,
                          input int max_t, input bit want_done);
    int left = rows;
    int addr = base;
    int i = 0;
    exp_err = 1'b0;
    if (rows == 0 || depth == 0) begin
      exp_err = 1'b1;
    end else begin
      while (left > 0 && i < max_t) begin
        if (addr + depth > 1024) begin
          exp_err = 1'b1;
          break;
        end
        exp_base.push_back(addr);
        exp_rows.push_back(left < 8 ? left : 8);
        exp_idx.push_back(i);
        left -= 8;
        addr += depth;
        i++;
      end
    end
    if (want_done) done_pend++;
  endtask

  task automatic flush_model();
    exp_base.delete();
    exp_rows.delete();
    exp_idx.delete();
    done_pend = 0;
  endtask

  task automatic do_start(input int rows, input int depth, input int base,
                          input int max_t, input bit want_done);
    plan_run(rows, depth, base, max_t, want_done);
    on_cyc.delete();
    done_cyc = -1;
    @(posedge clk);
    #1;
    cfg_rows = 16'(rows);
    cfg_depth = 10'(depth);
    cfg_base = 10'(base);
    start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_pend > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", done_pend, 0);
    chk("tiles_left", exp_base.size(), 0);
    flush_model();
    while (cyc <= done_cyc) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("stray_on", 32'(on && exp_base.size() == 0), 0);
        chk("stray_done", 32'(done && done_pend == 0), 0);
        if (on && exp_base.size() > 0) begin
          on_cyc.push_back(cyc);
          chk("tile_base", 32'(base_addr), exp_base.pop_front());
          chk("tile_rows", 32'(num_rows), exp_rows.pop_front());
          chk("tile_idx", 32'(tile_idx), exp_idx.pop_front());
        end
        if (done && done_pend > 0) begin
          chk("done_err", 32'(err), 32'(exp_err));
          done_pend--;
          done_cyc = cyc;
        end
      end
    end
  end

  // Array model: optional echo coincident with on, then tile_done later
  initial begin
    tile_done = 1'b0;
    forever begin
      @(negedge clk);
      if (on && reset) begin
        if (td_echo) begin
          #1 tile_done = 1'b1;
          @(posedge clk);
          #1 tile_done = 1'b0;
        end
        repeat (td_delay) @(posedge clk);
        #1 tile_done = 1'b1;
        @(posedge clk);
        #1 tile_done = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_rows = '0;
    cfg_depth = '0;
    cfg_base = '0;
    array_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_on", 32'(on), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_base", 32'(base_addr), 0);
    chk("rst_rows", 32'(num_rows), 0);
    chk("rst_idx", 32'(tile_idx), 0);
    @(posedge clk);
    #1 reset = 1'b1;

    do_start(20, 16, 0, 99, 1'b1);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_err", 32'(err), 0);
    wait_done(200);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_on_count", on_cyc.size(), 3);
    if (on_cyc.size() == 3) begin
      chk("t1_on0_lat", on_cyc[0] - c0, 1);
      chk("t1_on1_lat", on_cyc[1] - c0, 18);
      chk("t1_on2_lat", on_cyc[2] - c0, 35);
    end
    chk("t1_done_lat", done_cyc - c0, 52);

    do_start(8, 32, 1000, 99, 1'b1);
    wait_done(20);
    chk("ovf_on_count", on_cyc.size(), 0);
    chk("ovf_done_lat", done_cyc - c0, 2);
    chk("ovf_err_sticky", 32'(err), 1);

    do_start(0, 16, 0, 99, 1'b1);
    wait_done(20);
    chk("zero_done_lat", done_cyc - c0, 1);
    chk("zero_err_sticky", 32'(err), 1);

    do_start(8, 4, 100, 99, 1'b1);
    @(negedge clk);
    chk("fit_err_clear", 32'(err), 0);
    wait_done(100);
    chk("fit_on_count", on_cyc.size(), 1);

    do_start(20, 16, 1000, 99, 1'b1);
    wait_done(100);
    chk("late_ovf_on_count", on_cyc.size(), 1);

    array_ready = 1'b0;
    do_start(5, 10, 200, 99, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("bp_no_on", 32'(on), 0);
      chk("bp_base", 32'(base_addr), 200);
      chk("bp_rows", 32'(num_rows), 5);
    end
    @(posedge clk);
    #1 array_ready = 1'b1;
    wait_done(100);
    chk("bp_on_count", on_cyc.size(), 1);
    if (on_cyc.size() == 1) chk("bp_on_lat", on_cyc[0] - c0, 6);

    td_echo = 1'b1;
    td_delay = 6;
    do_start(8, 4, 0, 99, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("echo_busy", 32'(busy), 1);
    end
    wait_done(50);
    chk("echo_done_lat", done_cyc - c0, 9);
    td_echo = 1'b0;
    td_delay = 16;

    do_start(12, 8, 8, 99, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    cfg_rows = 16'd1;
    cfg_depth = 10'd1;
    cfg_base = 10'd500;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(200);
    chk("restart_on_count", on_cyc.size(), 2);

    do_start(20, 16, 0, 2, 1'b0);
    for (int k = 0; k < 100 && on_cyc.size() < 2; k++) @(negedge clk);
    chk("abort_reach_t1", on_cyc.size(), 2);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_err", 32'(err), 0);
    repeat (30) @(negedge clk);
    chk("abort_on_count", on_cyc.size(), 2);
    flush_model();

    do_start(20, 16, 48, 2, 1'b0);
    for (int k = 0; k < 100 && on_cyc.size() < 2; k++) @(negedge clk);
    chk("rstrun_reach_t1", on_cyc.size(), 2);
    chk("pre_reset_base", 32'(base_addr), 64);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_on", 32'(on), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_base", 32'(base_addr), 0);
    chk("mid_rst_rows", 32'(num_rows), 0);
    chk("mid_rst_idx", 32'(tile_idx), 0);
    flush_model();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
